// File: rtl/sram_drain_ctrl.sv
// sram_drain_ctrl: drains a window of result-SRAM words over valid/ready.
// Credit-limited reads feed a small skid FIFO so a ready consumer sees one word per cycle.
module sram_drain_ctrl #(
  parameter int DATA_W = 80,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              start_ovr,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, FIN} state_t;

  state_t state, nstate;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   issued;
  logic [RD_LAT-1:0] vpipe;
  logic [DATA_W-1:0] fifo_q [FIFO_D];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     occ, inflt;
  logic              accept, push, pop;
  logic              credit, last_xfer;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept    = start && (state == IDLE);
  assign push      = vpipe[RD_LAT-1];
  assign pop       = out_valid && out_ready;
  // reads in flight plus words held must fit the FIFO before a new read
  assign credit    = ({1'b0, inflt} + {1'b0, occ}) < (CW+1)'(FIFO_D);
  assign mem_rd_en = (state == ISSUE) && (issued != cnt_q) && credit;
  assign mem_addr  = base_q + issued[ADDR_W-1:0];
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? fifo_q[rptr] : '0;
  assign out_last  = out_valid && ((sent_cnt + ONE) == cnt_q);
  assign last_xfer = out_last && out_ready;
  assign busy      = (state == ISSUE) || (state == FLUSH);
  assign done      = (state == FIN);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (accept)
          nstate = (word_cnt == '0) ? FIN : ISSUE;
      ISSUE:
        if (mem_rd_en && ((issued + ONE) == cnt_q))
          nstate = FLUSH;
      FLUSH:
        if (last_xfer)
          nstate = FIN;
      FIN:
        nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      issued    <= '0;
      sent_cnt  <= '0;
      start_ovr <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        base_q    <= base_addr;
        cnt_q     <= word_cnt;
        issued    <= '0;
        sent_cnt  <= '0;
        start_ovr <= 1'b0;
      end else begin
        if (start)
          start_ovr <= 1'b1;
        if (mem_rd_en)
          issued <= issued + ONE;
        if (pop)
          sent_cnt <= sent_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      wptr  <= '0;
      rptr  <= '0;
      occ   <= '0;
      inflt <= '0;
    end else begin
      vpipe[0] <= mem_rd_en;
      for (int i = 1; i < RD_LAT; i++)
        vpipe[i] <= vpipe[i-1];
      if (push)
        wptr <= nxt(wptr);
      if (pop)
        rptr <= nxt(rptr);
      occ   <= occ + CW'(push) - CW'(pop);
      inflt <= inflt + CW'(mem_rd_en) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_sram_drain_ctrl.sv
// tb_sram_drain_ctrl: directed drains against a latency-modelled SRAM.
// Expected words are queued at start and popped on each accepted transfer.
module tb_sram_drain_ctrl;

  localparam int DW = 80;
  localparam int AW = 15;
  localparam int RL = 3;
  localparam int FD = RL + 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          start_ovr;
  logic [AW:0]   sent_cnt;

  sram_drain_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .word_cnt(word_cnt),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .start_ovr(start_ovr),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fmem(input logic [AW-1:0] a);
    return {1'b1, a, ~a, 16'hC3A5, a ^ 15'h2AAA, 3'b101, a};
  endfunction

  logic [DW-1:0] rpipe [RL];
  always @(posedge clk) begin
    rpipe[0] <= mem_rd_en ? fmem(mem_addr) : '1;
    for (int i = 1; i < RL; i++)
      rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  exp_t em;
  int errors = 0, checks = 0;
  int done_cnt = 0, rd_cnt = 0, xfer_cnt = 0;
  int valid_cnt = 0, busy_cnt = 0;
  int c0 = 0, first_valid_rel = -1, done_rel = -1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  bit rand_ready = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      if (busy) busy_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        chk("credit", DW'(rd_cnt - xfer_cnt <= FD), DW'(1));
      end
      if (prev_stall) begin
        chk("hold_valid", DW'(out_valid), DW'(1));
        chk("hold_data", out_data, prev_data);
        chk("hold_last", DW'(out_last), DW'(prev_last));
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_rel < 0) first_valid_rel = cyc - c0 + 1;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", DW'(q.size() != 0), DW'(1));
        if (q.size() != 0) begin
          em = q.pop_front();
          chk("sb_data", out_data, em.d);
          chk("sb_last", DW'(out_last), DW'(em.l));
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_cnt++;
        done_rel = cyc - c0 + 1;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 99) < 30);
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n,
                          input bit acc);
    @(posedge clk);
    #1;
    if (acc) begin
      for (int i = 0; i < int'(n); i++)
        q.push_back('{fmem(b + AW'(i)), (i == int'(n) - 1)});
      rd_cnt = 0;
      xfer_cnt = 0;
      valid_cnt = 0;
      busy_cnt = 0;
      done_cnt = 0;
      first_valid_rel = -1;
      done_rel = -1;
    end
    start = 1'b1;
    base_addr = b;
    word_cnt = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (acc) c0 = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(tag, DW'(done_cnt != d0), DW'(1));
  endtask

  task automatic wait_xfer(input int n, input int budget, input string tag);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(tag, DW'(xfer_cnt >= n), DW'(1));
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_rd_en"}, DW'(mem_rd_en), '0);
    chk({p, "_addr"}, DW'(mem_addr), '0);
    chk({p, "_valid"}, DW'(out_valid), '0);
    chk({p, "_data"}, out_data, '0);
    chk({p, "_last"}, DW'(out_last), '0);
    chk({p, "_busy"}, DW'(busy), '0);
    chk({p, "_done"}, DW'(done), '0);
    chk({p, "_ovr"}, DW'(start_ovr), '0);
    chk({p, "_sent"}, DW'(sent_cnt), '0);
  endtask

  initial begin
    int d0;
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_cnt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    do_start(AW'(0), (AW+1)'(5670), 1);
    chk("t1_busy", DW'(busy), DW'(1));
    wait_done(5670 + RL + 20, "t1_done");
    chk("t1_first_valid", DW'(first_valid_rel), DW'(RL + 2));
    chk("t1_done_cycle", DW'(done_rel), DW'(5670 + RL + 2));
    chk("t1_sent", DW'(sent_cnt), DW'(5670));
    chk("t1_reads", DW'(rd_cnt), DW'(5670));
    chk("t1_sb_empty", DW'(q.size()), DW'(0));
    chk("t1_idle", DW'(busy), DW'(0));

    do_start(AW'(32766), (AW+1)'(4), 1);
    wait_done(40, "t2_done");
    chk("t2_done_cycle", DW'(done_rel), DW'(4 + RL + 2));
    chk("t2_sent", DW'(sent_cnt), DW'(4));
    chk("t2_sb_empty", DW'(q.size()), DW'(0));

    do_start(AW'(123), (AW+1)'(0), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_done_cnt", DW'(done_cnt), DW'(1));
    chk("t3_done_rel", DW'(done_rel >= 1 && done_rel <= 2), DW'(1));
    chk("t3_reads", DW'(rd_cnt), DW'(0));
    chk("t3_valid", DW'(valid_cnt), DW'(0));
    chk("t3_busy", DW'(busy_cnt), DW'(0));
    chk("t3_sent", DW'(sent_cnt), DW'(0));

    rand_ready = 1;
    do_start(AW'(1234), (AW+1)'(300), 1);
    wait_done(4000, "t4_done");
    rand_ready = 0;
    out_ready = 1'b1;
    chk("t4_sent", DW'(sent_cnt), DW'(300));
    chk("t4_sb_empty", DW'(q.size()), DW'(0));

    do_start(AW'(500), (AW+1)'(200), 1);
    wait_xfer(100, 400, "t5_reach100");
    do_start(AW'(9), (AW+1)'(7), 0);
    chk("t5_ovr_set", DW'(start_ovr), DW'(1));
    chk("t5_busy", DW'(busy), DW'(1));
    wait_done(600, "t5_done");
    chk("t5_sent", DW'(sent_cnt), DW'(200));
    chk("t5_sb_empty", DW'(q.size()), DW'(0));
    chk("t5_ovr_kept", DW'(start_ovr), DW'(1));
    do_start(AW'(40), (AW+1)'(3), 1);
    chk("t5_ovr_clr", DW'(start_ovr), DW'(0));
    wait_done(40, "t5b_done");
    chk("t5b_sb_empty", DW'(q.size()), DW'(0));

    do_start(AW'(700), (AW+1)'(200), 1);
    wait_xfer(50, 400, "t6_reach50");
    #3;
    reset = 1'b0;
    #1;
    chk_zero("t6_async");
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    repeat (3) @(posedge clk);
    chk("t6_no_done", DW'(done_cnt), DW'(d0));
    do_start(AW'(700), (AW+1)'(20), 1);
    wait_done(60, "t6_done");
    chk("t6_sent", DW'(sent_cnt), DW'(20));
    chk("t6_sb_empty", DW'(q.size()), DW'(0));

    do_start(AW'(5), (AW+1)'(32768), 1);
    wait_done(32768 + 100, "t7_done");
    chk("t7_done_cycle", DW'(done_rel), DW'(32768 + RL + 2));
    chk("t7_sent", DW'(sent_cnt), DW'(32768));
    chk("t7_reads", DW'(rd_cnt), DW'(32768));
    chk("t7_sb_empty", DW'(q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
